// File: rtl/pim_conv_accum_if.sv
// Port bundle between the row-accumulation stage, its start/config source,
// the conv line it reads, and the pooling stage it feeds.
interface pim_conv_accum_if #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic signed [7:0]   bias;
    logic [ADDR_W-1:0]   conv_addr;
    logic                conv_en;
    logic signed [8:0]   conv_value;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic signed [7:0]   out_data;

    modport master (
        input  start, base_addr, bias, conv_value, out_ready,
        output conv_addr, conv_en, busy, out_valid, out_data
    );

    modport slave (
        output start, base_addr, bias, conv_value, out_ready,
        input  conv_addr, conv_en, busy, out_valid, out_data
    );
endinterface

// File: rtl/pim_conv_accum.sv
// Issues KROWS row reads per window, sums the tagged conv-line returns,
// adds bias, applies ReLU with 8-bit saturation and holds the result until taken.
module pim_conv_accum #(
    parameter int DEPTH = 32,
    parameter int KROWS = 5,
    parameter int LAT   = 1,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    pim_conv_accum_if.master   io
);
    localparam int ADDR_W = $clog2(DEPTH);
    // Shared by the ISSUE row index (< DEPTH) and the DRAIN countdown (< 4).
    localparam int CNT_W  = ADDR_W + 3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [ADDR_W-1:0]        base_q;
    logic signed [7:0]        bias_q;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic signed [ACC_W:0]    sum;
    logic signed [7:0]        out_q;
    logic [LAT-1:0]           vld_pipe;
    logic [ADDR_W:0]          addr_raw, addr_wrap;
    logic                     start_ok, issue_last, drain_last;

    assign start_ok   = (state == IDLE) && io.start;
    assign issue_last = (cnt == CNT_W'(KROWS - 1));
    assign drain_last = (cnt == CNT_W'(LAT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (io.start)   state_nxt = ISSUE;
            ISSUE: if (issue_last) state_nxt = DRAIN;
            DRAIN: if (drain_last) state_nxt = OUT;
            OUT:   if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_raw     = {1'b0, base_q} + cnt[ADDR_W:0];
        addr_wrap    = (addr_raw >= (ADDR_W+1)'(DEPTH)) ? addr_raw - (ADDR_W+1)'(DEPTH) : addr_raw;
        io.conv_en   = (state == ISSUE);
        io.conv_addr = (state == ISSUE) ? addr_wrap[ADDR_W-1:0] : '0;
        io.busy      = (state != IDLE);
        io.out_valid = (state == OUT);
        io.out_data  = out_q;
    end

    // Only a tag leaving the pipe lets conv_value into the accumulator.
    always_comb begin
        acc_nxt = acc;
        if (vld_pipe[LAT-1])
            acc_nxt = acc + {{(ACC_W-9){io.conv_value[8]}}, io.conv_value};
        sum = {acc_nxt[ACC_W-1], acc_nxt} + {{(ACC_W-7){bias_q[7]}}, bias_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            base_q   <= '0;
            bias_q   <= '0;
            acc      <= '0;
            vld_pipe <= '0;
            out_q    <= '0;
        end else begin
            vld_pipe[0] <= io.conv_en;
            for (int i = 1; i < LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];

            if (start_ok) begin
                cnt    <= '0;
                base_q <= io.base_addr;
                bias_q <= io.bias;
                acc    <= '0;
            end else begin
                acc <= acc_nxt;
                if ((state == ISSUE && issue_last) || (state == DRAIN && drain_last))
                    cnt <= '0;
                else if (state == ISSUE || state == DRAIN)
                    cnt <= cnt + CNT_W'(1);
            end

            // The last return lands in the final DRAIN cycle, so use acc_nxt here.
            if (state == DRAIN && drain_last) begin
                if (sum < 0)        out_q <= 8'sd0;
                else if (sum > 127) out_q <= 8'sd127;
                else                out_q <= sum[7:0];
            end
        end
    end
endmodule

// File: tb/tb_pim_conv_accum.sv
// Runs a LAT=1 and a LAT=3 instance side by side on identical stimulus,
// each fed by a stub conv line, with a result scoreboard per instance.
module tb_pim_conv_accum;
    localparam int DEPTH = 32;
    localparam int KROWS = 5;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [4:0]        base_addr = '0;
    logic signed [7:0] bias = '0;
    logic              out_ready = 1'b1;
    bit                fmode = 1'b0;
    logic [8:0]        fval9 = '0;

    int checks = 0;
    int failures = 0;
    int qa[$];
    int qb[$];

    pim_conv_accum_if #(.DEPTH(DEPTH)) ifa ();
    pim_conv_accum_if #(.DEPTH(DEPTH)) ifb ();

    pim_conv_accum #(.DEPTH(DEPTH), .KROWS(KROWS), .LAT(LAT_A), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .io(ifa));
    pim_conv_accum #(.DEPTH(DEPTH), .KROWS(KROWS), .LAT(LAT_B), .ACC_W(16)) dut_b (
        .clk(clk), .rst(rst), .io(ifb));

    assign ifa.start = start;      assign ifb.start = start;
    assign ifa.base_addr = base_addr; assign ifb.base_addr = base_addr;
    assign ifa.bias = bias;        assign ifb.bias = bias;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    function automatic logic [8:0] f(input logic [4:0] a);
        return fmode ? fval9 : {4'b0, a};
    endfunction

    // Stub conv lines: value for an address appears LAT cycles later.
    logic [8:0] sa [0:LAT_A-1];
    logic [8:0] sb [0:LAT_B-1];
    always @(posedge clk) begin
        sa[0] <= f(ifa.conv_addr);
        sb[0] <= f(ifb.conv_addr);
        for (int i = 1; i < LAT_B; i++) sb[i] <= sb[i-1];
    end
    assign ifa.conv_value = sa[LAT_A-1];
    assign ifb.conv_value = sb[LAT_B-1];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int model(input int base, input int b, input bit fm, input int fv);
        int s;
        s = b;
        for (int r = 0; r < KROWS; r++) s += fm ? fv : (base + r) % DEPTH;
        if (s < 0) return 0;
        if (s > 127) return 127;
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (ifa.out_valid) begin
                if (qa.size() == 0) chk("sb_a_extra", 1, 0);
                else chk("sb_a", int'(ifa.out_data), qa.pop_front());
            end
            if (ifb.out_valid) begin
                if (qb.size() == 0) chk("sb_b_extra", 1, 0);
                else chk("sb_b", int'(ifb.out_data), qb.pop_front());
            end
        end
    end

    task automatic check_issue(input string tag, input int c, input int base);
        bit en;
        en = (c >= 1 && c <= KROWS);
        chk($sformatf("%s.c%0d.en_a", tag, c), int'(ifa.conv_en), int'(en));
        chk($sformatf("%s.c%0d.en_b", tag, c), int'(ifb.conv_en), int'(en));
        if (en) begin
            chk($sformatf("%s.c%0d.addr_a", tag, c), int'(ifa.conv_addr), (base + c - 1) % DEPTH);
            chk($sformatf("%s.c%0d.addr_b", tag, c), int'(ifb.conv_addr), (base + c - 1) % DEPTH);
        end
    endtask

    // Full window with out_ready held high; checks issue, busy and valid timing.
    task automatic run_window(input string tag, input int base, input int b, input bit fm, input int fv);
        int e;
        bit va, vb;
        e = model(base, b, fm, fv);
        qa.push_back(e);
        qb.push_back(e);
        for (int c = 0; c <= KROWS + LAT_B + 1; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            start = (c == 0);
            if (c == 0) begin
                base_addr = 5'(base);
                bias = 8'(b);
                fmode = fm;
                fval9 = 9'(fv);
            end
            check_issue(tag, c, base);
            va = (c == KROWS + LAT_A + 1);
            vb = (c == KROWS + LAT_B + 1);
            chk($sformatf("%s.c%0d.vld_a", tag, c), int'(ifa.out_valid), int'(va));
            chk($sformatf("%s.c%0d.vld_b", tag, c), int'(ifb.out_valid), int'(vb));
            chk($sformatf("%s.c%0d.busy_a", tag, c), int'(ifa.busy), int'(c >= 1 && c <= KROWS + LAT_A + 1));
            chk($sformatf("%s.c%0d.busy_b", tag, c), int'(ifb.busy), int'(c >= 1 && c <= KROWS + LAT_B + 1));
            if (va) chk($sformatf("%s.data_a", tag), int'(ifa.out_data), e);
            if (vb) chk($sformatf("%s.data_b", tag), int'(ifb.out_data), e);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.en_a", int'(ifa.conv_en), 0);
        chk("rst.addr_a", int'(ifa.conv_addr), 0);
        chk("rst.busy_a", int'(ifa.busy), 0);
        chk("rst.vld_a", int'(ifa.out_valid), 0);
        chk("rst.data_a", int'(ifa.out_data), 0);
        chk("rst.busy_b", int'(ifb.busy), 0);
        chk("rst.vld_b", int'(ifb.out_valid), 0);
        rst = 1'b0;

        run_window("basic", 3, 0, 1'b0, 0);
        chk("model.basic", model(3, 0, 1'b0, 0), 25);
        run_window("relu_neg", 0, 10, 1'b1, -20);
        run_window("relu_small", 0, -30, 1'b1, 5);
        run_window("bias_neg", 0, -20, 1'b1, 5);
        run_window("sat_max", 0, 127, 1'b1, 255);
        run_window("sat_min", 0, 0, 1'b1, -256);
        run_window("edge_127", 0, 2, 1'b1, 25);
        run_window("edge_128", 0, 3, 1'b1, 25);
        run_window("wrap", 30, 0, 1'b0, 0);
        chk("model.wrap", model(30, 0, 1'b0, 0), 64);

        // Backpressure with starts during OUT and on the handshake cycle.
        qa.push_back(25);
        qb.push_back(25);
        for (int c = 0; c <= 11; c++) begin
            @(posedge clk); #1;
            start = (c == 0 || c == 8 || c == 11);
            base_addr = (c == 0) ? 5'd3 : 5'd10;
            bias = (c == 0) ? 8'sd0 : 8'sd50;
            fmode = 1'b0;
            out_ready = !(c >= 7 && c <= 10);
            check_issue("bp", c, 3);
            if (c >= 6) begin
                chk($sformatf("bp.c%0d.en_a", c), int'(ifa.conv_en), 0);
                chk($sformatf("bp.c%0d.en_b", c), int'(ifb.conv_en), 0);
            end
            if (c >= 7) begin
                chk($sformatf("bp.c%0d.vld_a", c), int'(ifa.out_valid), 1);
                chk($sformatf("bp.c%0d.data_a", c), int'(ifa.out_data), 25);
                chk($sformatf("bp.c%0d.busy_a", c), int'(ifa.busy), 1);
            end
            if (c >= 9) chk($sformatf("bp.c%0d.vld_b", c), int'(ifb.out_valid), 1);
        end
        start = 1'b0;
        run_window("after_hs", 0, 0, 1'b0, 0);
        chk("model.after_hs", model(0, 0, 1'b0, 0), 10);

        // Reset during ISSUE: nothing pushed, so any result would be flagged.
        for (int c = 0; c <= 24; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            base_addr = 5'd3;
            bias = 8'sd0;
            rst = (c == 3);
            if (c == 3) chk("rstmid.en_a", int'(ifa.conv_en), 1);
            if (c >= 4) begin
                chk($sformatf("rstmid.c%0d.en_a", c), int'(ifa.conv_en), 0);
                chk($sformatf("rstmid.c%0d.en_b", c), int'(ifb.conv_en), 0);
                chk($sformatf("rstmid.c%0d.vld_a", c), int'(ifa.out_valid), 0);
                chk($sformatf("rstmid.c%0d.vld_b", c), int'(ifb.out_valid), 0);
                chk($sformatf("rstmid.c%0d.busy_a", c), int'(ifa.busy), 0);
            end
        end
        rst = 1'b0;
        start = 1'b0;
        run_window("rst_recover", 0, 0, 1'b0, 0);

        @(posedge clk); #1;
        chk("sb_a_empty", qa.size(), 0);
        chk("sb_b_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pim_conv_accum.md
# pim_conv_accum

Row-accumulation stage placed directly downstream of the PIM convolution line. For each output pixel it issues the KROWS kernel-row addresses of one window to the conv line and tags each issued row, so the return lands after the conv line's read latency. It sums the returned 9-bit partial sums, adds a per-channel bias, applies ReLU with 8-bit saturation, and presents the result on a valid/ready port to the pooling stage. It processes one window at a time.

## Interface
Parameters:
- DEPTH, 32: number of conv-line rows; address width ADDR_W = clogb2(DEPTH).
- KROWS, 5: kernel rows summed per output pixel. Range 1..DEPTH.
- LAT, 1: cycles from conv_en/conv_addr to the matching conv_value. Range 1..4.
- ACC_W, 16: accumulator width, signed.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin one window; honoured only in IDLE.
- base_addr  in  ADDR_W  first row address, latched on an accepted start.
- bias  in  8  signed bias, latched on an accepted start.
- conv_addr  out  ADDR_W  row address to the conv line.
- conv_en  out  1  row-issue strobe to the conv line.
- conv_value  in  9  signed partial sum returned by the conv line.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  8  signed result, range 0..127.

## Operation
- States and transitions:
  - IDLE -> ISSUE on start.
  - ISSUE holds for exactly KROWS cycles, then moves to DRAIN.
  - DRAIN -> OUT once all KROWS tagged returns have been accumulated. DRAIN lasts LAT cycles.
  - OUT -> IDLE on out_valid && out_ready.
- Accepting start: clears the accumulator, clears the row counter, and latches base_addr and bias.
- ISSUE, row r (0..KROWS-1):
  - conv_en = 1.
  - conv_addr = (base_addr + r) mod DEPTH. Wrap-around is required, e.g. base 30 with DEPTH 32 issues 30, 31, 0, 1, 2.
- Return tagging: a LAT-deep shift register carries a tag for each issued row. When a tag exits, conv_value is sign-extended to ACC_W and added to the accumulator. Untagged cycles never modify the accumulator.
- Result, computed on entry to OUT: s = acc + sign_extend(bias).
  - s < 0 gives out_data = 0.
  - s > 127 gives out_data = 127.
  - Otherwise out_data = s[7:0].
- ACC_W = 16 cannot overflow for KROWS ≤ DEPTH ≤ 128, since 128·255 < 2^15.
- start outside IDLE is ignored, including the cycle of the OUT handshake. It never corrupts the latched base_addr or bias.
- conv_en is 0 in IDLE, DRAIN and OUT.

## Timing
- Reset values: conv_en 0, conv_addr 0, busy 0, out_valid 0, out_data 0. State is IDLE, tags and accumulator are cleared.
- Cycle numbering: start is high in cycle 0 and sampled at the end of cycle 0.
  - conv_en is high in cycles 1..KROWS.
  - The value for the row issued in cycle n is sampled at the end of cycle n+LAT.
  - out_valid rises in cycle KROWS+LAT+1. With the defaults this is cycle 7.
- busy rises in cycle 1. It falls in the cycle after the handshake, so the next start is accepted at the earliest one cycle after the handshake.
- Backpressure: out_valid and out_data stay stable until out_ready. out_valid is never retracted without a handshake.
- rst mid-operation, in any state:
  - Returns to the reset values on the next edge.
  - conv_en is 0 in the following cycle.
  - No out_valid is produced for the aborted window.
  - Late conv_value returns from the aborted window are discarded because the tags are cleared.
- rst and start in the same cycle: rst wins.

## Test plan
Default parameters unless stated. The conv line is replaced by a stub: a LAT-cycle pipeline returning f(conv_addr).
- Basic: f(a) = a, base 3, bias 0, out_ready tied 1. Expect conv_en in cycles 1–5 with addresses 3..7, then out_valid in cycle 7 with out_data 25 for one cycle, and busy low in cycle 8.
- Bias and ReLU:
  - f = −20, bias +10 gives s = −90, so out_data 0.
  - f = 5, bias −30 gives s = −5, so out_data 0.
  - f = 5, bias −20 gives out_data 5.
- Saturation and sign:
  - f = 255, bias 127 gives 127.
  - f = −256 gives 0.
  - f = 25, bias 2 gives exactly 127.
  - f = 25, bias 3 gives 127, saturated.
- Wrap and latency:
  - base 30, f(a) = a, LAT = 3 gives addresses 30, 31, 0, 1, 2, sum 64, out_valid in cycle 9.
- Backpressure and ignored start:
  - out_ready low for 4 cycles after out_valid. out_data stays 25 and busy stays 1.
  - start pulsed with base 10 during OUT and in the handshake cycle. Both are ignored: no second window, no conv_en.
  - A start in the cycle after busy falls is accepted.
- Reset mid-window:
  - rst in cycle 3 of ISSUE. Expect conv_en 0 from cycle 4 and no out_valid within 20 cycles.
  - A new start with base 0, f(a) = a gives out_data 10 with the normal timing.
